// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: controller state encoding and the
// default geometry with the address field widths it implies.
package dcache_pkg;

  localparam int CACHE_LINES = 16;
  localparam int CACHE_WORDS = 4;
  localparam int WORD_BITS   = $clog2(CACHE_WORDS);
  localparam int INDEX_BITS  = $clog2(CACHE_LINES);
  localparam int OFF_BITS    = 2 + WORD_BITS;
  localparam int TAG_BITS    = 32 - OFF_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRBACK = 2'd1,
    REFILL = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_if.sv
// Bundle of the pipeline request/response and the main-memory burst signals.
// Handshake: a request is held while dhit=0 and completes on the edge where
// dhit=1; a memory beat is offered while mem_req=1 and completes on the edge
// where mem_ack=1, with mem_req/mem_addr/mem_we/mem_wdata held until then.
interface dcache_if;
  logic        req_valid;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        dhit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata,
    input  rdata, dhit,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata,
    output rdata, dhit,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty metadata and line data storage for a direct-mapped cache.
// Combinational read by index/word; byte-enabled word write; line metadata update.
module dcache_array import dcache_pkg::*; #(
  parameter int LINES = CACHE_LINES,
  parameter int WORDS = CACHE_WORDS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [$clog2(LINES)-1:0]               rd_index,
  input  logic [$clog2(WORDS)-1:0]               rd_word,
  output logic [31:0]                            rd_data,
  output logic [31-2-$clog2(WORDS)-$clog2(LINES):0] rd_tag,
  output logic                                   rd_valid,
  output logic                                   rd_dirty,
  input  logic                                   wr_en,
  input  logic [$clog2(LINES)-1:0]               wr_index,
  input  logic [$clog2(WORDS)-1:0]               wr_word,
  input  logic [3:0]                             wr_be,
  input  logic [31:0]                            wr_data,
  input  logic                                   meta_fill,
  input  logic                                   dirty_set,
  input  logic [31-2-$clog2(WORDS)-$clog2(LINES):0] meta_tag
);

  localparam int TB = 32 - 2 - $clog2(WORDS) - $clog2(LINES);

  logic [31:0]   data_q [LINES][WORDS];
  logic [TB-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign rd_data  = data_q[rd_index][rd_word];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

  // Reset only clears the status bits; stale tags/data are unreachable once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (meta_fill) begin
        valid_q[wr_index] <= 1'b1;
        dirty_q[wr_index] <= 1'b0;
      end
      if (dirty_set) begin
        dirty_q[wr_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (meta_fill) begin
      tag_q[wr_index] <= meta_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_q[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the M stage.
// Misses are served by word-serial writeback and refill bursts to main memory.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int LINES = CACHE_LINES,
  parameter int WORDS = CACHE_WORDS
) (
  input  logic    clk,
  input  logic    reset,
  dcache_if.slave bus,
  output state_t  dbg_state
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int OB = 2 + WB;
  localparam int TB = 32 - OB - IB;

  state_t        state;
  logic [WB-1:0] beat;
  logic [IB-1:0] lat_index;
  logic [TB-1:0] lat_tag;
  logic [TB-1:0] vic_tag;
  logic          mem_req_q;
  logic          mem_we_q;

  logic [WB-1:0] req_word;
  logic [IB-1:0] req_index;
  logic [TB-1:0] req_tag;
  logic          in_idle;
  logic          hit;
  logic          idle_hit;
  logic          miss;
  logic          last_beat;
  logic          refill_ack;

  logic [IB-1:0] rd_index;
  logic [WB-1:0] rd_word;
  logic [31:0]   rd_data;
  logic [TB-1:0] rd_tag;
  logic          rd_valid;
  logic          rd_dirty;
  logic          wr_en;
  logic [IB-1:0] wr_index;
  logic [WB-1:0] wr_word;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          meta_fill;
  logic          dirty_set;

  assign req_word  = bus.req_addr[OB-1:2];
  assign req_index = bus.req_addr[OB+IB-1:OB];
  assign req_tag   = bus.req_addr[31:OB+IB];

  assign in_idle    = (state == IDLE);
  assign hit        = bus.req_valid && rd_valid && (rd_tag == req_tag);
  assign idle_hit   = in_idle && hit;
  assign miss       = in_idle && bus.req_valid && !hit;
  assign last_beat  = (beat == WB'(WORDS - 1));
  assign refill_ack = (state == REFILL) && bus.mem_ack;

  // Lookups use the live request in IDLE; bursts use the latched line address.
  assign rd_index = in_idle ? req_index : lat_index;
  assign rd_word  = in_idle ? req_word  : beat;

  assign wr_en     = (idle_hit && bus.req_write) || refill_ack;
  assign wr_index  = in_idle ? req_index : lat_index;
  assign wr_word   = in_idle ? req_word  : beat;
  assign meta_fill = refill_ack && last_beat;
  assign dirty_set = idle_hit && bus.req_write;

  // Big-endian byte lanes: offset 0 lands in bits [31:24].
  always_comb begin
    wr_be   = 4'hF;
    wr_data = bus.mem_rdata;
    if (in_idle) begin
      wr_data = bus.req_wdata;
      if (bus.req_byte) begin
        wr_be   = 4'b1000 >> bus.req_addr[1:0];
        wr_data = {4{bus.req_wdata[7:0]}};
      end
    end
  end

  dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (rd_index),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_word   (wr_word),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .meta_fill (meta_fill),
    .dirty_set (dirty_set),
    .meta_tag  (lat_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      lat_index <= '0;
      lat_tag   <= '0;
      vic_tag   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_index <= req_index;
            lat_tag   <= req_tag;
            vic_tag   <= rd_tag;
            beat      <= '0;
            mem_req_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state    <= WRBACK;
              mem_we_q <= 1'b1;
            end else begin
              state    <= REFILL;
              mem_we_q <= 1'b0;
            end
          end
        end
        WRBACK: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              beat     <= '0;
              state    <= REFILL;
              mem_we_q <= 1'b0;
            end else begin
              beat <= beat + WB'(1);
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              beat      <= '0;
              state     <= IDLE;
              mem_req_q <= 1'b0;
            end else begin
              beat <= beat + WB'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          beat      <= '0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dhit      = in_idle && (!bus.req_valid || hit);
  assign bus.rdata     = rd_data;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_req_q ? {((state == WRBACK) ? vic_tag : lat_tag), lat_index, beat, 2'b00} : 32'h0;
  assign bus.mem_wdata = (state == WRBACK) ? rd_data : 32'h0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a reference cache model predicts memory beats and load
// data into queues; a memory responder and the request driver pop and compare.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  dcache_if bus ();

  dcache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] exp_q [$];      // {we, addr, wdata} per memory beat
  logic [31:0] exp_rd_q [$];   // load data

  logic [31:0] tb_mem [logic [31:0]];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];

  bit          rand_gaps = 0;
  int          gap_left  = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  int          stall_seen = 0;
  bit          kill_armed = 0;
  bit          kill_hit   = 0;
  logic [31:0] kill_addr  = 32'hFFFF_FFFF;

  task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Reference model: predicts beats and load data, updates its own line state.
  task automatic model_access(input bit w, input bit b, input logic [31:0] a,
                              input logic [31:0] d, output bit miss);
    int idx;
    int wd;
    int lane;
    logic [23:0] tg;
    logic [31:0] ba;
    idx = int'(a[7:4]);
    wd  = int'(a[3:2]);
    tg  = a[31:8];
    miss = !(m_valid[idx] && m_tag[idx] == tg);
    if (miss) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int i = 0; i < 4; i++) begin
          ba = {m_tag[idx], a[7:4], 4'(i * 4)};
          exp_q.push_back({1'b1, ba, m_data[idx][i]});
        end
      end
      for (int i = 0; i < 4; i++) begin
        ba = {tg, a[7:4], 4'(i * 4)};
        exp_q.push_back({1'b0, ba, 32'h0});
        m_data[idx][i] = mem_rd(ba);
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (w) begin
      if (b) begin
        lane = 3 - int'(a[1:0]);
        m_data[idx][wd][8*lane +: 8] = d[7:0];
      end else begin
        m_data[idx][wd] = d;
      end
      m_dirty[idx] = 1'b1;
    end else begin
      exp_rd_q.push_back(m_data[idx][wd]);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic [64:0] e;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (kill_armed && bus.mem_addr == kill_addr) begin
          kill_hit = 1'b1;
        end else if (stall_left > 0 && bus.mem_addr == stall_addr) begin
          stall_left--;
          stall_seen++;
          check_eq("stall_dhit", bus.dhit, 1'b0);
        end else if (gap_left > 0) begin
          gap_left--;
        end else begin
          bus.mem_ack = 1'b1;
          if (exp_q.size() == 0) begin
            check_eq("beat_expected", 1'b0, 1'b1);
            bus.mem_rdata = mem_rd(bus.mem_addr);
          end else begin
            e = exp_q.pop_front();
            check_eq("beat_we", bus.mem_we, e[64]);
            check_eq("beat_addr", bus.mem_addr, e[63:32]);
            if (e[64]) begin
              check_eq("beat_wdata", bus.mem_wdata, e[31:0]);
              tb_mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
              bus.mem_rdata = mem_rd(bus.mem_addr);
            end
          end
          gap_left = rand_gaps ? int'($urandom_range(0, 2)) : 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit w, input bit b, input logic [31:0] a,
                        input logic [31:0] d, output bit miss, output int cyc);
    logic [31:0] er;
    model_access(w, b, a, d, miss);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte  = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    check_eq("first_dhit", bus.dhit, !miss);
    if (!miss) check_eq("hit_no_memreq", bus.mem_req, 1'b0);
    cyc = 0;
    while (bus.dhit !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("dhit_timeout", bus.dhit, 1'b1);
    if (!w && exp_rd_q.size() != 0) begin
      er = exp_rd_q.pop_front();
      check_eq("rdata", bus.rdata, er);
    end
    check_eq("beats_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_eq({tag, "_dhit"}, bus.dhit, 1'b1);
    check_eq({tag, "_memreq"}, bus.mem_req, 1'b0);
    check_eq({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          miss;
    int          cyc;
    logic [31:0] a;
    bit          w;
    bit          b;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) tb_mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_quiet("reset");
    @(negedge clk);
    check_eq("reset_memwe", bus.mem_we, 1'b0);

    // 1: cold load, refill-only penalty of 1 + 4 beats
    do_req(0, 0, 32'h40, 32'h0, miss, cyc);
    check_eq("t1_penalty", cyc, 5);
    // 2: store hit then reload
    do_req(1, 0, 32'h44, 32'hDEAD_BEEF, miss, cyc);
    do_req(0, 0, 32'h44, 32'h0, miss, cyc);
    check_quiet("idle");
    // 3: byte store, offset 2 -> bits [15:8]
    do_req(1, 1, 32'h46, 32'h0000_00AB, miss, cyc);
    do_req(0, 0, 32'h44, 32'h0, miss, cyc);
    // 4: dirty victim -> writeback then refill
    do_req(0, 0, 32'h140, 32'h0, miss, cyc);
    check_eq("t4_penalty", cyc, 9);
    // 5: clean victim, beat 1 stalled 3 cycles
    stall_addr = 32'h244;
    stall_left = 3;
    stall_seen = 0;
    do_req(0, 0, 32'h240, 32'h0, miss, cyc);
    check_eq("t5_stall_seen", stall_seen, 3);
    check_eq("t5_penalty", cyc, 8);

    // 6: reset in the middle of a refill
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'h340 + 32'(4 * i), 32'h0});
    kill_addr  = 32'h348;
    kill_hit   = 1'b0;
    kill_armed = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h340;
    cyc = 0;
    while (!kill_hit && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("t6_reached_beat2", kill_hit, 1'b1);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    check_quiet("t6_after_reset");
    @(posedge clk);
    #1;
    reset      = 1'b0;
    kill_armed = 1'b0;
    check_eq("t6_left_beats", exp_q.size(), 2);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    do_req(0, 0, 32'h140, 32'h0, miss, cyc);
    check_eq("t6_remiss", miss, 1'b1);
    check_eq("t6_remiss_penalty", cyc, 5);
    // written-back byte-store data comes back from memory
    do_req(0, 0, 32'h44, 32'h0, miss, cyc);

    // random mix over 4 tags x 4 lines with random ack gaps
    rand_gaps = 1;
    for (int k = 0; k < 60; k++) begin
      w = bit'($urandom_range(0, 1));
      b = w ? bit'($urandom_range(0, 1)) : 1'b0;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | (b ? 32'($urandom_range(0, 3)) : 32'h0);
      do_req(w, b, a, $urandom, miss, cyc);
    end
    rand_gaps = 0;
    check_quiet("end");
    check_eq("end_rd_q_empty", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
